// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit: run states and
// increment/alignment derivation from the instruction width.
package pc_unit_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  function automatic int unsigned inc_of(input int unsigned word);
    return word / 8;
  endfunction

  // Bits of a target that must be zero for the fetch to be word aligned.
  function automatic int unsigned align_mask_of(input int unsigned word);
    return inc_of(word) - 1;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras
  import pc_unit_pkg::*;
#(
  parameter int unsigned ADDR  = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            replace_i,
  input  logic [ADDR-1:0] data_i,
  output logic [ADDR-1:0] top_c,
  output logic            empty_o,
  output logic            full_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [ADDR-1:0] mem_q [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d, top_idx;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            empty_q, full_q;

  // ptr_q is the next free slot; the top lives one below it.
  assign top_idx = ptr_q - PW'(1);
  assign top_c   = mem_q[top_idx];
  assign empty_o = empty_q;
  assign full_o  = full_q;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (replace_i) begin
      ptr_d = ptr_q;
    end else if (push_i) begin
      ptr_d = ptr_q + PW'(1);
      if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + CW'(1);
    end else if (pop_i && (cnt_q != '0)) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && replace_i) begin
      mem_q[top_idx] <= data_i;
    end else if (!rst && push_i) begin
      mem_q[ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with sequential fetch, absolute/relative redirects,
// call/return through a return-address stack and sticky fault halt.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned ADDR         = 16,
  parameter int unsigned WORD         = 32,
  parameter int unsigned RESET_VECTOR = 0,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic            redir_rel,
  input  logic [ADDR-1:0] redir_addr,
  input  logic            call,
  input  logic            ret,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [ADDR-1:0] addr_o,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            fault
);

  localparam int unsigned   INC        = inc_of(WORD);
  localparam logic [ADDR-1:0] ALIGN_MASK = ADDR'(align_mask_of(WORD));

  pc_state_e       state_q, state_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic            fault_q, fault_d;
  logic            fv_q;
  logic            push, pop, replace;
  logic [ADDR-1:0] target, ret_addr, ras_top;
  logic            fire;

  assign fire     = fv_q & fetch_ready & ~stall;
  assign target   = redir_rel ? (addr_q + redir_addr) : redir_addr;
  assign ret_addr = addr_q + ADDR'(INC);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    fault_d = fault_q;
    push    = 1'b0;
    pop     = 1'b0;
    replace = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect) begin
          if ((target & ALIGN_MASK) != '0) begin
            fault_d = 1'b1;
            state_d = HALT;
          end else begin
            addr_d = target;
            // call+ret on a non-empty stack swaps the top instead of growing it
            if (call && ret && !ras_empty) replace = 1'b1;
            else if (call)                 push    = 1'b1;
          end
        end else if (ret) begin
          if (ras_empty) begin
            fault_d = 1'b1;
            state_d = HALT;
          end else begin
            pop    = 1'b1;
            addr_d = ras_top;
          end
        end else if (fire) begin
          addr_d = ret_addr;
        end
      end
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      addr_q  <= ADDR'(RESET_VECTOR);
      fault_q <= 1'b0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      fault_q <= fault_d;
      fv_q    <= (state_d == RUN);
    end
  end

  pc_ras #(
    .ADDR (ADDR),
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push),
    .pop_i    (pop),
    .replace_i(replace),
    .data_i   (ret_addr),
    .top_c    (ras_top),
    .empty_o  (ras_empty),
    .full_o   (ras_full)
  );

  assign addr_o      = addr_q;
  assign fetch_valid = fv_q;
  assign fault       = fault_q;

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter ADDR, default 16: address width in bits; all address ports are ADDR bits.
REQ-002 SHALL have parameter WORD, default 32: instruction width; increment INC = WORD/8.
REQ-003 SHALL have parameter RESET_VECTOR, default 0: PC value loaded on reset.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, power of two, minimum 2: return-address-stack entries.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port stall, input, 1: hold the PC; no sequential advance.
REQ-008 SHALL have port redirect, input, 1: load a new PC from redir_addr (branch/jump/call).
REQ-009 SHALL have port redir_rel, input, 1: 0 = absolute target; 1 = target is addr_o + redir_addr.
REQ-010 SHALL have port redir_addr, input, ADDR: target or signed offset.
REQ-011 SHALL have port call, input, 1: qualifies redirect; push return address addr_o+INC.
REQ-012 SHALL have port ret, input, 1: pop the stack and load the popped value as the PC.
REQ-013 SHALL have port fetch_valid, output, 1: addr_o is a valid fetch request.
REQ-014 SHALL have port fetch_ready, input, 1: instruction memory accepts the request.
REQ-015 SHALL have port addr_o, output, ADDR: current PC.
REQ-016 SHALL have ports ras_empty and ras_full, output, 1 each: stack status.
REQ-017 SHALL have port fault, output, 1: sticky misalignment/underflow error.

Function
REQ-018 SHALL implement states BOOT, RUN and HALT. BOOT goes to RUN after one cycle. RUN goes to HALT on a fault. HALT is left only through rst.
REQ-019 fetch_valid SHALL be 1 only in RUN; fire = fetch_valid & fetch_ready & ~stall.
REQ-020 Priority in RUN SHALL be: redirect, then ret, then sequential advance.
REQ-021 Redirect and ret SHALL take effect on the next edge regardless of stall or fetch_ready; they flush the current request.
REQ-022 Sequential advance SHALL occur only on fire: addr_o <= addr_o + INC, modulo 2^ADDR (wraps to 0).
REQ-023 With no fire, no redirect and no ret, addr_o SHALL hold its value.
REQ-024 Relative targets SHALL be computed as the ADDR-bit sum, modulo 2^ADDR, with redir_addr in two's complement.
REQ-025 A call with redirect SHALL push (addr_o + INC) mod 2^ADDR and load the target.
REQ-026 When the stack is full, a push SHALL overwrite the oldest entry (circular), keep ras_full=1 and raise no fault.
REQ-027 A ret SHALL pop the top entry into addr_o.
REQ-028 A ret on an empty stack SHALL set fault, enter HALT and leave addr_o unchanged.
REQ-029 If redirect&call and ret are asserted together, the stack SHALL replace its top entry: net depth unchanged, the new PC is the redirect target.
REQ-030 If redirect (without call) and ret are asserted together, redirect SHALL win and the stack SHALL be unchanged.
REQ-031 call without redirect SHALL be ignored.
REQ-032 A target whose low log2(INC) bits are nonzero SHALL set fault and enter HALT; the PC is not loaded.
REQ-033 In HALT, fetch_valid SHALL be 0 and all inputs except rst SHALL be ignored.

Reset
REQ-034 On rst, on the same edge: addr_o=RESET_VECTOR, state=BOOT, fetch_valid=0, stack emptied (ras_empty=1, ras_full=0), fault=0.
REQ-035 rst asserted mid-operation SHALL override every other input on that edge.
REQ-036 fetch_valid SHALL first be 1 on the second edge after rst deasserts.

Structure
REQ-037 A shared package SHALL hold the state enumeration (BOOT/RUN/HALT) and the INC/alignment-mask derivation.
REQ-038 The return-address stack SHALL be a sub-module, pc_ras: a circular buffer with a pointer and a count, push/pop/replace operations and full/empty outputs.

Verification
REQ-039 Reset, then fetch_ready=1 for 4 cycles, ADDR=16: addr_o = 0, 0, 4, 8, 12; fetch_valid rises on the second edge.
REQ-040 PC=0xFFFC, fire: addr_o=0x0000. Relative redirect from PC=0x0010 with offset 0xFFF0: addr_o=0x0000.
REQ-041 stall=1 and fetch_ready=0 for 3 cycles: addr_o holds. Redirect to 0x0100 during the stall: addr_o=0x0100 on the next edge.
REQ-042 5 calls from PCs 0x00,0x10,0x20,0x30,0x40, then 4 rets: addr_o=0x44, 0x34, 0x24, 0x14; then ras_empty=1. A 5th ret: fault=1, state HALT, fetch_valid=0.
REQ-043 Redirect to 0x0102: fault=1, addr_o unchanged, fetch_valid=0. rst: addr_o=RESET_VECTOR, fault=0.
REQ-044 Simultaneous call-redirect and ret: stack depth unchanged, top entry = new return address, addr_o = target.
